stream_low_pass: RTL and testbench

STREAM_LOW_PASS -- requirements
Module: stream_low_pass

---
 rtl/stream_low_pass_pkg.sv | 19 +
 rtl/stream_low_pass_line_buffer.sv | 20 ++
 rtl/stream_low_pass.sv | 129 ++++++++++++
 tb/tb_stream_low_pass.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/stream_low_pass_pkg.sv
// stream_low_pass_pkg: shared mode/state encodings and binomial kernel constants
package stream_low_pass_pkg;
    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_LOW    = 2'd1,
        MODE_HIGH   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;
    localparam int K_CORNER = 1;
    localparam int K_EDGE   = 2;
    localparam int K_CENTRE = 4;
    localparam int K_SHIFT  = 4;
    localparam int K_ROUND  = 1 << (K_SHIFT - 1);
endpackage

// File: rtl/stream_low_pass_line_buffer.sv
// stream_low_pass_line_buffer: one-line RAM, synchronous write, combinational read-old-data
module stream_low_pass_line_buffer #(
    parameter int WORDS = 410,
    parameter int DW = 8,
    localparam int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem_q [WORDS];
    // write port; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_addr] <= wr_data;
    end
    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/stream_low_pass.sv
// stream_low_pass: streaming 3x3 binomial low/high-pass filter with edge replication
module stream_low_pass
    import stream_low_pass_pkg::*;
#(
    parameter int WIDTH = 410,
    parameter int DEPTH = 361,
    parameter int COLOR_DEPTH = 8,
    parameter int CHANNELS = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      mode,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CHANNELS*COLOR_DEPTH-1:0] in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CHANNELS*COLOR_DEPTH-1:0] out_data,
    output logic                            out_last
);
    localparam int PW = CHANNELS * COLOR_DEPTH;
    localparam int SW = COLOR_DEPTH + 4;
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(DEPTH + 2);

    state_e state_q, state_d;
    mode_e mode_q, mode_d;
    logic [XW-1:0] ix_q, ix_d;
    logic [YW-1:0] iy_q, iy_d;
    logic sel_q, sel_d;
    logic [2:0][PW-1:0] wa_q, wa_d, wb_q, wb_d, vec, lc, rc;
    logic [PW-1:0] rd0, rd1, top, mid, bot, res, out_data_q, out_data_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic room, acc, step, emit, col_end, fin;

    stream_low_pass_line_buffer #(.WORDS(WIDTH), .DW(PW)) u_lb0 (
        .clk(clk), .we(acc && !sel_q), .wr_addr(ix_q), .wr_data(in_data), .rd_addr(ix_q), .rd_data(rd0)
    );
    stream_low_pass_line_buffer #(.WORDS(WIDTH), .DW(PW)) u_lb1 (
        .clk(clk), .we(acc && sel_q), .wr_addr(ix_q), .wr_data(in_data), .rd_addr(ix_q), .rd_data(rd1)
    );

    assign room = !out_valid_q || out_ready;
    assign in_ready = (state_q != ST_FLUSH) && room;
    assign acc = in_valid && in_ready;
    assign step = acc || (state_q == ST_FLUSH && room && !out_last_q);
    assign emit = step && state_q != ST_FILL;
    assign col_end = ix_q == XW'(WIDTH - 1);
    assign fin = iy_q == YW'(DEPTH + 1);
    assign mid = sel_q ? rd0 : rd1;
    assign top = (iy_q == YW'(1)) ? mid : (sel_q ? rd1 : rd0);
    assign bot = (iy_q == YW'(DEPTH)) ? mid : in_data;
    assign vec = {bot, mid, top};
    assign lc = (ix_q == XW'(1)) ? wb_q : wa_q;
    assign rc = (ix_q == '0) ? wb_q : vec;
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_last = out_last_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        localparam int B = i * COLOR_DEPTH;
        logic [SW-1:0] sum;
        logic [COLOR_DEPTH-1:0] cen, lp, hp;
        assign cen = wb_q[1][B +: COLOR_DEPTH];
        assign sum = SW'(K_CORNER) * (SW'(lc[0][B +: COLOR_DEPTH]) + SW'(lc[2][B +: COLOR_DEPTH])
                                    + SW'(rc[0][B +: COLOR_DEPTH]) + SW'(rc[2][B +: COLOR_DEPTH]))
                   + SW'(K_EDGE) * (SW'(lc[1][B +: COLOR_DEPTH]) + SW'(rc[1][B +: COLOR_DEPTH])
                                  + SW'(wb_q[0][B +: COLOR_DEPTH]) + SW'(wb_q[2][B +: COLOR_DEPTH]))
                   + SW'(K_CENTRE) * SW'(cen);
        assign lp = COLOR_DEPTH'((sum + SW'(K_ROUND)) >> K_SHIFT);
        assign hp = (cen > lp) ? cen - lp : '0;
        assign res[B +: COLOR_DEPTH] = (mode_q == MODE_LOW) ? lp : (mode_q == MODE_HIGH) ? hp : cen;
    end

    // control, window and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            mode_q      <= MODE_BYPASS;
            ix_q        <= '0;
            iy_q        <= '0;
            sel_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            ix_q        <= ix_d;
            iy_q        <= iy_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
        wa_q <= wa_d;
        wb_q <= wb_d;
    end

    // one step per accepted pixel (or per flush slot): advance position, shift window, load output
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ix_d        = ix_q;
        iy_d        = iy_q;
        sel_d       = sel_q;
        wa_d        = wa_q;
        wb_d        = wb_q;
        out_valid_d = room ? 1'b0 : out_valid_q;
        out_last_d  = room ? 1'b0 : out_last_q;
        out_data_d  = out_data_q;
        if (step) begin
            ix_d  = (fin || col_end) ? '0 : ix_q + 1'b1;
            iy_d  = fin ? '0 : col_end ? iy_q + 1'b1 : iy_q;
            sel_d = sel_q ^ col_end;
            wa_d  = wb_q;
            wb_d  = vec;
        end
        if (emit) begin
            out_valid_d = 1'b1;
            out_last_d  = fin;
            out_data_d  = res;
        end
        if (acc && ix_q == '0 && iy_q == '0) mode_d = mode_e'(mode);
        if (state_q == ST_FILL && acc && ix_q == '0 && iy_q == YW'(1)) state_d = ST_RUN;
        if (state_q == ST_RUN && acc && col_end && iy_q == YW'(DEPTH - 1)) state_d = ST_FLUSH;
        if (state_q == ST_FLUSH && out_valid_q && out_last_q && out_ready) state_d = ST_FILL;
    end
endmodule

// File: tb/tb_stream_low_pass.sv
// tb_stream_low_pass: directed scenario bench for stream_low_pass on 5x5 frames, 3 channels
module tb_stream_low_pass;
    localparam int N = 25;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [23:0] in_data = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [23:0] out_data;
    logic out_last;
    int checks = 0;
    int errors = 0;
    logic [23:0] pix [2*N];
    logic [23:0] exp_d [2*N];
    logic [23:0] got_d [2*N];
    logic got_l [2*N];
    int got_n, cyc_n, unstable, stuck;

    always #5 clk = ~clk;

    stream_low_pass #(.WIDTH(5), .DEPTH(5), .COLOR_DEPTH(8), .CHANNELS(3)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    task automatic run_frames(input int nfr, input logic [1:0] md, input bit stall);
        got_n = 0;
        cyc_n = 0;
        unstable = 0;
        stuck = 0;
        fork
            begin
                for (int k = 0; k < nfr * N; k++) begin
                    bit t;
                    int g;
                    while (stall && $urandom_range(0, 2) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    in_valid = 1'b1;
                    in_data = pix[k];
                    mode = (k % N == 0) ? md : 2'(k);
                    t = 1'b0;
                    g = 0;
                    while (!t && g < 2000) begin
                        @(negedge clk);
                        t = in_ready;
                        g++;
                        @(posedge clk);
                        #1;
                    end
                    if (!t) stuck++;
                end
                in_valid = 1'b0;
            end
            begin
                logic [23:0] hd;
                logic hl;
                bit hold;
                hold = 1'b0;
                hd = '0;
                hl = 1'b0;
                while (got_n < nfr * N && cyc_n < 3000) begin
                    out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                    @(negedge clk);
                    cyc_n++;
                    if (hold && !(out_valid && out_data == hd && out_last == hl)) unstable++;
                    hold = out_valid && !out_ready;
                    hd = out_data;
                    hl = out_last;
                    if (out_valid && out_ready) begin
                        got_d[got_n] = out_data;
                        got_l[got_n] = out_last;
                        got_n++;
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
    endtask

    function automatic logic [7:0] imp_lp(input int k);
        return (k == 12) ? 8'd64 : (k == 7 || k == 11 || k == 13 || k == 17) ? 8'd32 :
               (k == 6 || k == 8 || k == 16 || k == 18) ? 8'd16 : 8'd0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", out_last); end
        checks++; if (out_data !== 24'h0) begin errors++; $display("FAIL reset_out_data got %h want 000000", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_constant();
        for (int k = 0; k < N; k++) pix[k] = {3{8'd100}};
        run_frames(1, 2'd1, 1'b0);
        checks++; if (got_n !== N) begin errors++; $display("FAIL const_lp_count got %0d want %0d", got_n, N); end
        checks++; if (cyc_n > 34) begin errors++; $display("FAIL const_lp_cycles got %0d want <=34", cyc_n); end
        for (int k = 0; k < got_n; k++) begin
            checks++; if (got_d[k] !== {3{8'd100}}) begin errors++; $display("FAIL const_lp_data idx %0d got %h want 646464", k, got_d[k]); end
            checks++; if (got_l[k] !== (k == N - 1)) begin errors++; $display("FAIL const_lp_last idx %0d got %b want %b", k, got_l[k], k == N - 1); end
        end
        run_frames(1, 2'd2, 1'b0);
        checks++; if (got_n !== N) begin errors++; $display("FAIL const_hp_count got %0d want %0d", got_n, N); end
        for (int k = 0; k < got_n; k++) begin
            checks++; if (got_d[k] !== 24'h0) begin errors++; $display("FAIL const_hp_data idx %0d got %h want 000000", k, got_d[k]); end
        end
        repeat (8) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL const_idle got %b want 0", out_valid); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_impulse();
        for (int k = 0; k < N; k++) pix[k] = '0;
        pix[12] = 24'h0000FF;
        run_frames(1, 2'd1, 1'b0);
        checks++; if (got_n !== N) begin errors++; $display("FAIL imp_lp_count got %0d want %0d", got_n, N); end
        for (int k = 0; k < got_n; k++) begin
            checks++; if (got_d[k] !== {16'h0, imp_lp(k)}) begin errors++; $display("FAIL imp_lp_data idx %0d got %h want %h", k, got_d[k], {16'h0, imp_lp(k)}); end
        end
        pix[12] = 24'h00FF00;
        run_frames(1, 2'd2, 1'b0);
        checks++; if (got_n !== N) begin errors++; $display("FAIL imp_hp_count got %0d want %0d", got_n, N); end
        for (int k = 0; k < got_n; k++) begin
            exp_d[k] = (k == 12) ? 24'h00BF00 : 24'h0;
            checks++; if (got_d[k] !== exp_d[k]) begin errors++; $display("FAIL imp_hp_data idx %0d got %h want %h", k, got_d[k], exp_d[k]); end
        end
    endtask

    task automatic test_bypass();
        for (int k = 0; k < N; k++) pix[k] = {8'(k * 7), 8'(255 - k), 8'(k)};
        for (int m = 0; m < 2; m++) begin
            run_frames(1, (m == 0) ? 2'd0 : 2'd3, 1'b0);
            checks++; if (got_n !== N) begin errors++; $display("FAIL bypass_count mode %0d got %0d want %0d", m * 3, got_n, N); end
            for (int k = 0; k < got_n; k++) begin
                checks++; if (got_d[k] !== pix[k]) begin errors++; $display("FAIL bypass_data mode %0d idx %0d got %h want %h", m * 3, k, got_d[k], pix[k]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2 * N; k++) begin
            pix[k] = '0;
            exp_d[k] = '0;
        end
        pix[0] = 24'hFF0000;
        exp_d[0] = 24'h8F0000;
        exp_d[1] = 24'h300000;
        exp_d[5] = 24'h300000;
        exp_d[6] = 24'h100000;
        pix[49] = 24'h0000FF;
        exp_d[49] = 24'h00008F;
        exp_d[48] = 24'h000030;
        exp_d[44] = 24'h000030;
        exp_d[43] = 24'h000010;
        for (int s = 0; s < 2; s++) begin
            run_frames(2, 2'd1, s == 1);
            checks++; if (got_n !== 2 * N) begin errors++; $display("FAIL b2b_count stall %0d got %0d want %0d", s, got_n, 2 * N); end
            checks++; if (stuck !== 0) begin errors++; $display("FAIL b2b_input_stuck stall %0d got %0d want 0", s, stuck); end
            checks++; if (unstable !== 0) begin errors++; $display("FAIL b2b_hold_stable stall %0d got %0d want 0", s, unstable); end
            for (int k = 0; k < got_n; k++) begin
                checks++; if (got_d[k] !== exp_d[k]) begin errors++; $display("FAIL b2b_data stall %0d idx %0d got %h want %h", s, k, got_d[k], exp_d[k]); end
                checks++; if (got_l[k] !== (k % N == N - 1)) begin errors++; $display("FAIL b2b_last stall %0d idx %0d got %b want %b", s, k, got_l[k], k % N == N - 1); end
            end
        end
    endtask

    task automatic test_abort();
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'b1;
            in_data = 24'hC8C8C8;
            mode = 2'd2;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_reset_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_reset_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) pix[k] = {3{8'd50}};
        run_frames(1, 2'd1, 1'b0);
        checks++; if (got_n !== N) begin errors++; $display("FAIL abort_count got %0d want %0d", got_n, N); end
        for (int k = 0; k < got_n; k++) begin
            checks++; if (got_d[k] !== {3{8'd50}}) begin errors++; $display("FAIL abort_data idx %0d got %h want 323232", k, got_d[k]); end
            checks++; if (got_l[k] !== (k == N - 1)) begin errors++; $display("FAIL abort_last idx %0d got %b want %b", k, got_l[k], k == N - 1); end
        end
        repeat (8) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", out_valid); end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_constant();
        test_impulse();
        test_bypass();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
